// File: rtl/vram_port_arbiter.sv
// Shares one single-port video RAM between the CPU load/store port and a FIFO-buffered
// camera pixel write stream. CPU has priority, bounded by a starvation limit and FIFO-full.
module vram_port_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  // CPU data port
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  output logic                          cpu_stall,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic                          cpu_rvalid,
  // Camera pixel write stream
  input  logic                          cam_valid,
  output logic                          cam_ready,
  input  logic [ADDR_W-1:0]             cam_addr,
  input  logic [DATA_W-1:0]             cam_data,
  // RAM side
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic                          ram_we,
  input  logic [DATA_W-1:0]             ram_q,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  localparam logic [PtrW:0]   LevelFull = FIFO_DEPTH[PtrW:0];
  localparam logic [CntW-1:0] StarveMax = STARVE_MAX[CntW-1:0];

  // Camera FIFO storage (no reset needed: occupancy is tracked by the level)
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   level_q, level_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic cam_grant;
  logic cpu_grant;

  // ---------------------------------------------------------------------------
  // FIFO status and handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LevelFull);
    // Ready depends on level only, so a same-cycle pop never frees a slot early.
    cam_ready  = !fifo_full;
    push       = cam_valid && cam_ready;
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    cam_grant = !fifo_empty && (fifo_full || (starve_q == StarveMax) || !cpu_req);
    cpu_grant = cpu_req && !cam_grant;
    pop       = cam_grant;
    cpu_stall = cpu_req && !cpu_grant;
  end

  // ---------------------------------------------------------------------------
  // RAM drive
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = 1'b0;
    if (cam_grant) begin
      ram_addr  = addr_mem[rd_ptr_q];
      ram_wdata = data_mem[rd_ptr_q];
      ram_we    = 1'b1;
    end else if (cpu_grant) begin
      ram_we    = cpu_we;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || cam_grant) begin
      starve_d = '0;
    end else if (cpu_grant && (starve_q != StarveMax)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Load data is returned by the RAM the cycle after the grant; keep the last value.
  always_comb begin
    rvalid_d   = cpu_grant && !cpu_we;
    rdata_d    = rvalid_q ? ram_q : rdata_q;
    cpu_rvalid = rvalid_q;
    cpu_rdata  = rvalid_q ? ram_q : rdata_q;
    fifo_level = level_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      starve_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      starve_q <= starve_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= cam_addr;
      data_mem[wr_ptr_q] <= cam_data;
    end
  end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares one synchronous single-port video RAM between the ARM data port (load/store) and the camera pixel write stream.
- Camera writes are buffered in a parametrised FIFO. The CPU has priority, bounded by a starvation limit and a FIFO-full override.
- Sits between the core's ALUResult/WriteData/ReadData/write_enable path and the RAM_VIDEO instance.
- Generalises the fixed 32-bit/16-bit-address CPU-only hookup to configurable widths, a second requester, and a read-valid handshake.

Parameters:
- DATA_W, 32, data word width for CPU, camera and RAM.
- ADDR_W, 16, RAM word-address width.
- FIFO_DEPTH, 8, camera write FIFO entries (power of two, at least 2).
- STARVE_MAX, 4, maximum consecutive CPU grants while the FIFO is non-empty.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cpu_req  in  1  CPU access request, held until granted.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_stall  out  1  high when cpu_req is high and the CPU is not granted this cycle.
- cpu_rdata  out  DATA_W  load data, valid when cpu_rvalid is high.
- cpu_rvalid  out  1  one-cycle pulse, the cycle after a granted load.
- cam_valid  in  1  camera pixel write valid.
- cam_ready  out  1  FIFO can accept a pixel.
- cam_addr  in  ADDR_W  pixel word address.
- cam_data  in  DATA_W  pixel data.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_q  in  DATA_W  RAM read data, one-cycle latency after the address cycle.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - FIFO is emptied: fifo_level=0, read and write pointers = 0.
  - Starvation counter = 0.
  - cpu_rvalid=0 and cpu_rdata=0.
  - A load issued in the cycle before reset produces no rvalid.
  - Combinational outputs follow the idle rules below.
- **FIFO push:**
  - cam_ready = (fifo_level < FIFO_DEPTH), combinational from level only.
  - A push occurs when cam_valid && cam_ready. {cam_addr, cam_data} is stored.
  - There is no bypass when full: a pop in the same cycle as full does not raise cam_ready.
- **FIFO pop:** occurs when the camera is granted. Simultaneous push and pop leaves the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- **Arbitration:** combinational each cycle. Let fe = (fifo_level==0). Camera wins (cam_grant) if:
  - !fe && (fifo_level==FIFO_DEPTH), or
  - !fe && starve_cnt==STARVE_MAX, or
  - !fe && !cpu_req.
  - Otherwise, if cpu_req, the CPU wins (cpu_grant).
  - Otherwise the cycle is idle.
- **Starvation counter:**
  - Increments on each cpu_grant while !fe.
  - Cleared on cam_grant, or on any cycle where fe.
  - Saturates at STARVE_MAX.
- **RAM drive (combinational):**
  - cam_grant: ram_addr = FIFO head address, ram_wdata = head data, ram_we=1.
  - cpu_grant: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_we.
  - idle: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=0.
- **CPU load:**
  - Granted load in cycle N gives cpu_rvalid=1 in cycle N+1.
  - cpu_rdata is ram_q in N+1, held in a register until the next rvalid.
  - A store does not raise rvalid.
- **Stall:** cpu_stall = cpu_req && !cpu_grant. The CPU holds its request stable while stalled.
- **No write forwarding:** a CPU load of an address still pending in the FIFO returns the RAM contents; software ordering is the CPU's responsibility.
- **Back-to-back loads:** one per cycle is supported when granted each cycle. rvalid then stays high with new data each cycle.

Test Plan:
- **CPU only:** reset, then store 0xDEADBEEF to 0x0010, then load 0x0010. Required: ram_we=1 in the store cycle, no stall; cpu_rvalid=1 exactly one cycle after the load grant with cpu_rdata=0xDEADBEEF.
- **Camera only:** push 3 pixels (0x0100/0x11, 0x0101/0x22, 0x0102/0x33) with cpu_req=0. Required: fifo_level peaks at 1; three ram_we cycles in order; level returns to 0.
- **Starvation limit:** fill 2 pixels, hold cpu_req=1 continuously with loads. Required: the CPU is granted 4 cycles, then 1 camera grant with cpu_stall=1, then the CPU again; the pattern repeats until the FIFO is empty, after which the CPU is granted every cycle.
- **Full FIFO:** cpu_req=1 and cam_valid=1 every cycle. Required: the level climbs to 8 only if the starvation rule allows; at level 8, cam_ready=0 and the camera is granted; no pixel is lost; the order of pixel writes at the RAM equals push order, including across pointer wrap.
- **Simultaneous push and pop at level 3:** required: level stays 3 and the head entry is written to RAM.
- **Reset mid-load:** assert reset low in the cycle after a load grant. Required: cpu_rvalid stays 0, fifo_level=0, cam_ready=1 immediately (asynchronously).
